// File: rtl/score_bcd_seq.sv
// score_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Converts `score` one bit per clock and holds the last completed result
// on `bcd`. A conversion starts on `start` or, with `auto_en`, whenever
// `score` differs from the last converted value.
// Optional feature: define BCD_BLANK_EN to add the registered `blank`
// leading-zero suppression output.
module score_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      score,
  input  logic                  start,
  input  logic                  auto_en,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

`ifdef BCD_BLANK_EN
  // Reset display of 0: every digit above the ones digit is blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1'b1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q,   bin_d;    // bits still to be shifted in
  logic [WIDTH-1:0]  cap_q,   cap_d;    // value captured at the trigger
  logic [WIDTH-1:0]  last_q,  last_d;   // value of last completed result
  logic [BW-1:0]     acc_q,   acc_d;    // BCD scratch accumulator
  logic [BW-1:0]     bcd_q,   bcd_d;    // displayed result
  logic [CW-1:0]     cnt_q,   cnt_d;    // shifts remaining
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [BW-1:0]     acc_adj;           // acc after the add-3 correction
  logic              trigger;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
`endif

  // Add 3 to every BCD digit that is 5 or more, so the following left
  // shift carries correctly into the next digit.
  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

`ifdef BCD_BLANK_EN
  // Bit i (i >= 1) is set when digit i and every higher digit are zero.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] b);
    logic [DIGITS-1:0] r;
    logic              all_zero;
    r        = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (b[4*i +: 4] == 4'd0);
      r[i]     = all_zero;
    end
    return r;
  endfunction
`endif

  // Trigger condition evaluated only while idle.
  always_comb begin
    trigger = start || (auto_en && (score != last_q));
  end

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    bin_d   = bin_q;
    cap_d   = cap_q;
    last_d  = last_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    acc_adj = add3_digits(acc_q);
`ifdef BCD_BLANK_EN
    blank_d = blank_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          bin_d   = score;
          cap_d   = score;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Correction first, then one left shift of the {acc, bin} pair.
        {acc_d, bin_d} = {acc_adj, bin_q} << 1;
        cnt_d          = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = acc_d;
          last_d  = cap_q;
`ifdef BCD_BLANK_EN
          blank_d = blank_of(acc_d);
`endif
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of where the FSM is heading.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      // NOTE: the scratch registers are reset too; they are a handful of
      // flops, and a clean reset keeps simulation free of X propagation.
      state_q <= ST_IDLE;
      bin_q   <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_q <= BLANK_RST;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd   = bcd_q;
`ifdef BCD_BLANK_EN
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_score_bcd_seq.sv
// Testbench for score_bcd_seq: a cycle-count reference model pushes the
// expected value of each accepted conversion into a queue; a monitor on
// the falling edge checks busy/done timing and pops results on done.
module tb_score_bcd_seq;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int BW = 4 * D;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [W-1:0]  score;
  logic          start;
  logic          auto_en;
  logic          busy;
  logic          done;
  logic [BW-1:0] bcd;
`ifdef BCD_BLANK_EN
  logic [D-1:0]  blank;
`endif

  score_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .score   (score),
    .start   (start),
    .auto_en (auto_en),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
`ifdef BCD_BLANK_EN
    ,
    .blank   (blank)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v, packed four bits per digit.
  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Leading-zero mask: bit i set when v has no digit at position i or above.
  function automatic logic [D-1:0] blank_ref(input int v);
    logic [D-1:0] r;
    int p;
    r = '0;
    p = 10;
    for (int i = 1; i < D; i++) begin
      r[i] = ((v / p) == 0);
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: a conversion occupies W+2 edges; the result is due
  // on the W-th edge after the accepting edge.
  int           rem;
  logic [W-1:0] m_last;
  logic [W-1:0] exp_q[$];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem    = 0;
      m_last = '0;
      exp_q.delete();
    end else if (rem > 0) begin
      rem = rem - 1;
    end else if (start || (auto_en && (score != m_last))) begin
      rem    = W + 1;
      m_last = score;
      exp_q.push_back(score);
    end
  end

  // Monitor: compare status every falling edge, pop a result on done.
  logic [BW-1:0] shown;
  logic [D-1:0]  shown_blank;
  logic [W-1:0]  popped;

  always @(negedge clock) begin
    if (!reset_n) begin
      shown       = '0;
      shown_blank = blank_ref(0);
      check("rst_bcd",  32'(bcd),  32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
    end else begin
      check("busy", 32'(busy), 32'(rem > 0));
      check("done", 32'(done), 32'(rem == 1));
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL done_unexpected: got done with bcd 0x%0h, expected no result at %0t",
                   bcd, $time);
        end else begin
          popped      = exp_q.pop_front();
          shown       = to_bcd(int'(popped));
          shown_blank = blank_ref(int'(popped));
        end
      end
      check("bcd", 32'(bcd), 32'(shown));
    end
`ifdef BCD_BLANK_EN
    check("blank", 32'(blank), 32'(shown_blank));
`endif
  end

  // Wait (bounded) for a done pulse, sampled on the falling edge.
  task automatic wait_done(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: got no done within %0d cycles, expected done", name, max_cycles);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    score   = 8'd99;
    start   = 1'b1;
    auto_en = 1'b0;
    step(4);
    start   = 1'b0;
    reset_n = 1'b1;
    step(10);

    // Manual conversion of 255.
    score = 8'd255;
    pulse_start();
    wait_done("manual", 20);
    check("manual_bcd", 32'(bcd), 32'h255);
    step(3);

    // Auto mode: 42 converts once, then holding it produces nothing.
    auto_en = 1'b1;
    score   = 8'd42;
    wait_done("auto42", 20);
    check("auto_bcd", 32'(bcd), 32'h042);
    step(50);

    // Score changes three cycles into a conversion.
    score = 8'd40;
    wait_done("auto40", 20);
    step(2);
    score = 8'd42;
    step(3);
    score = 8'd43;
    wait_done("chg_first", 20);
    check("chg_first_bcd", 32'(bcd), 32'h042);
    wait_done("chg_second", 20);
    check("chg_second_bcd", 32'(bcd), 32'h043);
    step(3);

    // Reset in the middle of a conversion of 200.
    score = 8'd200;
    step(4);
    reset_n = 1'b0;
    #1;
    check("midrst_bcd",  32'(bcd),  32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    auto_en = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(15);

`ifdef BCD_BLANK_EN
    score = 8'd7;
    pulse_start();
    wait_done("blank7", 20);
    check("blank7", 32'(blank), 32'(3'b110));
    step(2);
    score = 8'd100;
    pulse_start();
    wait_done("blank100", 20);
    check("blank100", 32'(blank), 32'(3'b000));
    step(2);
    score = 8'd0;
    pulse_start();
    wait_done("blank0", 20);
    check("blank0", 32'(blank), 32'(3'b110));
    step(2);
`endif

    // Randomized traffic: score changes, start pulses, mode toggles, resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 4) begin
        reset_n = 1'b0;
        step($urandom_range(1, 3));
        reset_n = 1'b1;
      end else begin
        if (r < 80) score = W'($urandom);
        if (r >= 980) auto_en = ~auto_en;
        start = ($urandom_range(0, 11) == 0);
        step(1);
      end
    end

    // Drain and confirm every expected result was delivered.
    start   = 1'b0;
    auto_en = 1'b0;
    step(2 * W + 6);
    check("drain_queue", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
